vector_write_back_queue: RTL and testbench

- Elastic buffer directly downstream of the write-back vector masking unit; accepts masked destination packets (tag + 64-bit data) and delivers them to the vector register file write port.
- Absorbs cycles when the register-file write port is stalled (ready low), preserves program order, and reports whether a given destination tag still has a write pending. The issue stage uses this as a RAW hazard query.

---
 rtl/vector_write_back_queue.sv | 109 ++++++++++
 tb/tb_vector_write_back_queue.sv | 136 +++++++++++++
 2 files changed

// File: rtl/vector_write_back_queue.sv
// vector_write_back_queue
//   Elastic FIFO between the write-back masking unit and the vector register
//   file write port. It keeps packets in program order, absorbs write-port
//   stalls, and answers "is a write to this tag still pending" for the issue
//   stage's RAW hazard check.
//
//   Optional feature: define VECTOR_WRITE_BACK_QUEUE_BYPASS_EN to forward an
//   incoming packet straight to the output when the queue is empty.
//
// Ports
//   clock, reset           clock, synchronous active-high reset
//   flush                  synchronous squash of all entries
//   in_valid/in_ready      upstream handshake, in_tag/in_data payload
//   out_valid/out_ready    register-file handshake, out_tag/out_data head
//   query_tag/query_hit    pending-write probe (combinational)
//   occupancy              number of stored entries
module vector_write_back_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5,
  parameter int DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic [TAG_WIDTH-1:0]       query_tag,
  output logic                       query_hit,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]                        wr_ptr, rd_ptr;
  logic [DEPTH-1:0][TAG_WIDTH-1:0]      tag_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     data_q;
  logic [DEPTH-1:0]                     vld_q;
  logic [DEPTH-1:0]                     hit_vec;

  logic [AW-1:0] wr_idx, rd_idx;
  logic          empty, full, push, pop;

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign occupancy = wr_ptr - rd_ptr;

  // Readiness ignores out_ready on purpose: no pass-through when full.
  assign in_ready  = !full && !flush;
  assign pop       = !empty && out_ready;

`ifdef VECTOR_WRITE_BACK_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = empty && in_valid && !flush;
  assign out_valid = !empty || bypass;
  assign out_tag   = empty ? in_tag  : tag_q[rd_idx];
  assign out_data  = empty ? in_data : data_q[rd_idx];
  // A bypassed packet taken by the register file the same cycle is never stored.
  assign push      = in_valid && in_ready && !(bypass && out_ready);
`else
  assign out_valid = !empty;
  assign out_tag   = tag_q[rd_idx];
  assign out_data  = data_q[rd_idx];
  assign push      = in_valid && in_ready;
`endif

  // Per-entry tag match for the hazard query; popped entry still hits this cycle.
  for (genvar e = 0; e < DEPTH; e++) begin : g_hit
    assign hit_vec[e] = vld_q[e] && (tag_q[e] == query_tag);
  end
  assign query_hit = |hit_vec;

  // Control state. Push and pop never hit the same slot: that would need the
  // queue to be both not-full and not-empty with equal indices.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld_q  <= '0;
    end else begin
      if (push) begin
        vld_q[wr_idx] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        vld_q[rd_idx] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
    end
  end

  // Payload storage needs no reset; valid bits gate every use of it.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      tag_q[wr_idx]  <= in_tag;
      data_q[wr_idx] <= in_data;
    end
  end

endmodule

// File: tb/tb_vector_write_back_queue.sv
module tb_vector_write_back_queue;

  localparam int DW    = 64;
  localparam int TW    = 5;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready, query_hit;
  logic [TW-1:0] in_tag, out_tag, query_tag;
  logic [DW-1:0] in_data, out_data;
  logic [$clog2(DEPTH):0] occupancy;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } pkt_t;

  pkt_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clock = ~clock;

  vector_write_back_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .query_tag(query_tag), .query_hit(query_hit), .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // One clock cycle: drive inputs, compare comb outputs against the
  // scoreboard mid-cycle, update the model, then advance past the edge.
  task automatic step(input logic iv, input logic [TW-1:0] t, input logic [DW-1:0] d,
                      input logic ordy, input logic fl, input logic rs,
                      input logic [TW-1:0] q);
    logic e_full, e_empty, e_byp, e_hit, e_push;
    in_valid = iv; in_tag = t; in_data = d; out_ready = ordy;
    flush = fl; reset = rs; query_tag = q;
    #2;
    e_full  = (sb.size() == DEPTH);
    e_empty = (sb.size() == 0);
    e_byp   = 1'b0;
`ifdef VECTOR_WRITE_BACK_QUEUE_BYPASS_EN
    e_byp   = e_empty && iv && !fl;
`endif
    chk("in_ready", DW'(in_ready), DW'(!e_full && !fl));
    chk("out_valid", DW'(out_valid), DW'(!e_empty || e_byp));
    if (e_byp) begin
      chk("byp_tag", DW'(out_tag), DW'(t));
      chk("byp_data", out_data, d);
    end else if (!e_empty) begin
      chk("out_tag", DW'(out_tag), DW'(sb[0].tag));
      chk("out_data", out_data, sb[0].data);
    end
    e_hit = 1'b0;
    foreach (sb[i]) if (sb[i].tag == q) e_hit = 1'b1;
    chk("query_hit", DW'(query_hit), DW'(e_hit));
    chk("occupancy", DW'(occupancy), DW'(sb.size()));
    if (fl || rs) sb.delete();
    else begin
      e_push = iv && !e_full && !(e_byp && ordy);
      if (ordy && !e_empty) void'(sb.pop_front());
      if (e_push) sb.push_back('{tag: t, data: d});
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_tag = '0; in_data = '0; query_tag = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Idle after reset
    step(0, 0, 0, 0, 0, 0, 5);

    // Fill to full, reject a fifth push, then drain in order
    step(1, 1, {8{8'h11}}, 0, 0, 0, 0);
    step(1, 2, {8{8'h22}}, 0, 0, 0, 0);
    step(1, 3, {8{8'h33}}, 0, 0, 0, 0);
    step(1, 4, {8{8'h44}}, 0, 0, 0, 0);
    step(1, 5, {8{8'h55}}, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Steady state at occupancy 2 with simultaneous push/pop; pointers wrap
    step(1, 20, 64'hA5A5_0000_0000_0014, 0, 0, 0, 0);
    step(1, 21, 64'hA5A5_0000_0000_0015, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(1, TW'(i), 64'hC3C3_0000_0000_0000 | 64'(i), 1, 0, 0, TW'(i));
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Hazard query, including hit during the pop cycle
    step(1, 7, 64'h7777, 0, 0, 0, 0);
    step(1, 9, 64'h9999, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 8);
    step(0, 0, 0, 1, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, 7);
    step(0, 0, 0, 1, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 9);

    // Flush overrides a simultaneous push
    for (int i = 0; i < 3; i++) step(1, TW'(10 + i), 64'(i), 0, 0, 0, 0);
    step(1, 12, 64'hCCCC, 0, 1, 0, 12);
    step(0, 0, 0, 0, 0, 0, 12);

    // Reset mid-operation clears the same way
    for (int i = 0; i < 3; i++) step(1, TW'(10 + i), 64'(i), 0, 0, 0, 0);
    step(1, 12, 64'hCCCC, 0, 0, 1, 12);
    step(0, 0, 0, 0, 0, 0, 12);

    // Empty-queue forwarding (taken directly when bypass is built in)
    step(1, 3, 64'hDEAD_BEEF_0000_0001, 1, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 3);
    step(0, 0, 0, 1, 0, 0, 3);
    step(1, 3, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 3);
    step(0, 0, 0, 1, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
